// File: rtl/vga_color_sequencer_if.sv
// vga_color_sequencer_if: button/frame inputs and colour outputs of the colour sequencer
//   btn_next    raw asynchronous push button, active-high
//   auto_en     1 = automatic advance every AUTO_FRAMES frames
//   frame_start 1-cycle pulse at start of vertical blank
//   color_idx   current palette index
//   red/green/blue current colour channels
//   pending     manual advance accepted, waiting for frame_start
interface vga_color_sequencer_if;
   logic       btn_next;
   logic       auto_en;
   logic       frame_start;
   logic [2:0] color_idx;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       pending;
   modport master (output btn_next, auto_en, frame_start, input color_idx, red, green, blue, pending);
   modport slave  (input btn_next, auto_en, frame_start, output color_idx, red, green, blue, pending);
endinterface

// File: rtl/vga_color_sequencer.sv
// vga_color_sequencer: background palette selector, advanced by debounced button or auto frame count, applied at frame start
//   clk    pixel clock
//   reset  synchronous, active-high
//   bus_io slave side of vga_color_sequencer_if (button, auto enable, frame pulse in; index, RGB, pending out)
module vga_color_sequencer #(
   parameter int NUM_COLORS      = 5,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_FRAMES     = 60
) (
   input logic                  clk,
   input logic                  reset,
   vga_color_sequencer_if.slave bus_io
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int FW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(AUTO_FRAMES - 1);
   localparam logic [2:0] IDX_LAST = 3'(NUM_COLORS - 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ARMED = 1'b1;
   localparam logic [23:0] PAL [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                                       24'h000000, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
   logic          sync1_q, sync2_q, deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] frm_q, frm_d;
   logic [0:0]    state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          diff, settle, press, manual, auto_hit, adv;
   // The debounce counter only runs while the synchronised input disagrees with the debounced level
   always_comb begin
      diff     = sync2_q ^ deb_q;
      settle   = diff && cnt_q == DEB_LAST;
      cnt_d    = (!diff || settle) ? '0 : cnt_q + CW'(1);
      deb_d    = settle ? sync2_q : deb_q;
      press    = settle && sync2_q;
      manual   = state_q == ARMED && bus_io.frame_start;
      auto_hit = bus_io.auto_en && bus_io.frame_start && frm_q == FRM_LAST;
      adv      = manual || auto_hit;
      // A press coinciding with frame_start in IDLE arms for the following frame
      state_d  = state_q == IDLE ? (press ? ARMED : IDLE) : (bus_io.frame_start ? IDLE : ARMED);
      frm_d    = (!bus_io.auto_en || adv) ? '0 : bus_io.frame_start ? frm_q + FW'(1) : frm_q;
      idx_d    = adv ? (idx_q == IDX_LAST ? 3'd0 : idx_q + 3'd1) : idx_q;
      rgb_d    = PAL[idx_d];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         frm_q   <= '0;
         state_q <= IDLE;
         idx_q   <= 3'd0;
         rgb_q   <= 24'hFF0000;
      end else begin
         sync1_q <= bus_io.btn_next;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         frm_q   <= frm_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         rgb_q   <= rgb_d;
      end
   end
   assign bus_io.color_idx = idx_q;
   assign bus_io.red       = rgb_q[23:16];
   assign bus_io.green     = rgb_q[15:8];
   assign bus_io.blue      = rgb_q[7:0];
   assign bus_io.pending   = state_q == ARMED;
endmodule

// File: tb/tb_vga_color_sequencer.sv
// tb_vga_color_sequencer: scoreboard bench; expected output states queued with stimulus, monitor checks each output change
module tb_vga_color_sequencer;
   typedef struct {
      string      name;
      logic [27:0] v;
      int         t;
      int         lim;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   logic [27:0] prev, cur;
   vga_color_sequencer_if bus();
   vga_color_sequencer #(.NUM_COLORS(5), .DEBOUNCE_CYCLES(4), .AUTO_FRAMES(3)) dut (
      .clk(clk), .reset(reset), .bus_io(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [23:0] pal(int i);
      logic [23:0] p [8];
      p = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
      return p[i];
   endfunction
   task automatic push(input string nm, input int idx, input bit p, input int lim);
      exp_t e;
      e.name = nm;
      e.v    = {3'(idx), pal(idx), p};
      e.t    = cyc;
      e.lim  = lim;
      q.push_back(e);
   endtask
   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic frame();
      bus.frame_start = 1'b1;
      clks(1);
      bus.frame_start = 1'b0;
   endtask
   task automatic press_hold();
      bus.btn_next = 1'b1;
      clks(10);
      bus.btn_next = 1'b0;
      clks(10);
   endtask
   always @(negedge clk) begin
      cur = {bus.color_idx, bus.red, bus.green, bus.blue, bus.pending};
      if (cur !== prev) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (cur !== e.v) begin
               failures++;
               $display("FAIL %s cyc=%0d got idx/rgb/pend=%h expected=%h", e.name, cyc, cur, e.v);
            end
         end
         prev = cur;
      end else if (q.size() > 0 && cyc - q[0].t > q[0].lim) begin
         checks++;
         failures++;
         $display("FAIL %s timeout cyc=%0d got=%h expected=%h", q[0].name, cyc, cur, q[0].v);
         void'(q.pop_front());
      end
   end
   initial begin
      int ai[5] = '{3, 4, 0, 1, 2};
      int k = 0;
      reset = 1'b1;
      bus.btn_next = 1'b0;
      bus.auto_en = 1'b0;
      bus.frame_start = 1'b0;
      push("reset", 0, 0, 4);
      clks(3);
      reset = 1'b0;
      clks(3);
      push("t1_pending", 0, 1, 9);
      press_hold();
      push("t1_advance", 1, 0, 2);
      frame();
      clks(3);
      push("t2_pending", 1, 1, 20);
      for (int i = 0; i < 4; i++) begin
         bus.btn_next = ~i[0];
         clks(2);
      end
      press_hold();
      push("t2_advance", 2, 0, 2);
      frame();
      clks(3);
      bus.auto_en = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         if (i % 3 == 0) begin
            push("t3_auto", ai[k], 0, 2);
            k++;
         end
         frame();
         clks(2);
      end
      frame();
      clks(2);
      frame();
      clks(2);
      push("t4_armed", 2, 1, 9);
      press_hold();
      push("t4_coincident", 3, 0, 2);
      frame();
      clks(2);
      frame();
      clks(2);
      frame();
      clks(2);
      push("t4_next_auto", 4, 0, 2);
      frame();
      clks(2);
      frame();
      clks(2);
      push("t4b_armed", 4, 1, 9);
      press_hold();
      push("t4b_manual_wrap", 0, 0, 2);
      frame();
      clks(2);
      frame();
      clks(2);
      frame();
      clks(2);
      push("t4b_auto_after_reset_count", 1, 0, 2);
      frame();
      clks(2);
      bus.auto_en = 1'b0;
      push("t5_armed_same_cycle", 1, 1, 9);
      bus.btn_next = 1'b1;
      clks(5);
      bus.frame_start = 1'b1;
      clks(1);
      bus.frame_start = 1'b0;
      clks(10);
      bus.btn_next = 1'b0;
      clks(10);
      push("t5_advance", 2, 0, 2);
      frame();
      clks(3);
      push("t6_armed", 2, 1, 9);
      press_hold();
      push("t6_reset", 0, 0, 2);
      reset = 1'b1;
      clks(1);
      reset = 1'b0;
      clks(2);
      frame();
      clks(3);
      push("t6_hold_pending", 0, 1, 9);
      bus.btn_next = 1'b1;
      clks(10);
      push("t6_hold_reset", 0, 0, 2);
      reset = 1'b1;
      clks(1);
      reset = 1'b0;
      push("t6_held_press", 0, 1, 9);
      clks(10);
      bus.btn_next = 1'b0;
      clks(10);
      push("t6_advance", 1, 0, 2);
      frame();
      clks(5);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain left=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
